// File: rtl/uivtc_pkg.sv
// rtl/uivtc_pkg.sv - timing presets, FSM encoding and window helper for the video timing controller
package uivtc_pkg;

  localparam int CNT_W     = 12;
  localparam int CNT_LIMIT = 4095;

  localparam int P720_H_ACTIVE  = 1280;
  localparam int P720_H_FP      = 110;
  localparam int P720_H_SYNC    = 40;
  localparam int P720_H_BP      = 220;
  localparam int P720_V_ACTIVE  = 720;
  localparam int P720_V_FP      = 5;
  localparam int P720_V_SYNC    = 5;
  localparam int P720_V_BP      = 20;

  localparam int P1080_H_ACTIVE = 1920;
  localparam int P1080_H_FP     = 88;
  localparam int P1080_H_SYNC   = 44;
  localparam int P1080_H_BP     = 148;
  localparam int P1080_V_ACTIVE = 1080;
  localparam int P1080_V_FP     = 4;
  localparam int P1080_V_SYNC   = 5;
  localparam int P1080_V_BP     = 36;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } vtc_state_t;

  // Half-open window [lo, hi) on a raster counter.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/uivtc_axis_cnt.sv
// rtl/uivtc_axis_cnt.sv - wrapping raster counter with clear, increment and wrap flag
module uivtc_axis_cnt
  import uivtc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] cnt_max,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  // wrap is combinational so the next axis can advance on the same edge.
  assign wrap = inc && (cnt == cnt_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uivtc_gen.sv
// rtl/uivtc_gen.sv - vs/hs/de raster generator with pixel coordinates and start-of-frame pulse
module uivtc_gen
  import uivtc_pkg::*;
#(
  parameter int H_ACTIVE = P720_H_ACTIVE,
  parameter int H_FP     = P720_H_FP,
  parameter int H_SYNC   = P720_H_SYNC,
  parameter int H_BP     = P720_H_BP,
  parameter int V_ACTIVE = P720_V_ACTIVE,
  parameter int V_FP     = P720_V_FP,
  parameter int V_SYNC   = P720_V_SYNC,
  parameter int V_BP     = P720_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
)(
  input  logic             I_vtc_clk,
  input  logic             I_vtc_rst,
  input  logic             I_vtc_en,
  output logic             O_vtc_vs,
  output logic             O_vtc_hs,
  output logic             O_vtc_de,
  output logic [CNT_W-1:0] O_vtc_x,
  output logic [CNT_W-1:0] O_vtc_y,
  output logic             O_vtc_sof
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  generate
    if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT) begin : g_range_err
      $error("uivtc_gen: H_TOTAL and V_TOTAL must not exceed 4095");
    end
  endgenerate

  vtc_state_t       state, state_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap;
  logic             counting, cnt_clr;
  logic             h_act, v_act;

  assign counting = (state != ST_IDLE);

  uivtc_axis_cnt u_h_cnt (
    .clk     (I_vtc_clk),
    .rst     (I_vtc_rst),
    .clr     (cnt_clr),
    .inc     (counting),
    .cnt_max (H_MAX),
    .cnt     (h_cnt),
    .wrap    (h_wrap)
  );

  // v_wrap marks the last cycle of the frame (h and v both at their maximum).
  uivtc_axis_cnt u_v_cnt (
    .clk     (I_vtc_clk),
    .rst     (I_vtc_rst),
    .clr     (cnt_clr),
    .inc     (h_wrap),
    .cnt_max (V_MAX),
    .cnt     (v_cnt),
    .wrap    (v_wrap)
  );

  always_ff @(posedge I_vtc_clk or posedge I_vtc_rst) begin
    if (I_vtc_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (I_vtc_en) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!I_vtc_en) state_nxt = ST_STOPPING;
      end
      ST_STOPPING: begin
        // Stopping only ever lands on a frame boundary so frames are never truncated.
        if (I_vtc_en) begin
          state_nxt = ST_RUN;
        end else if (v_wrap) begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  assign h_act = in_window(h_cnt, H_ACT_LO, H_ACT_HI);
  assign v_act = in_window(v_cnt, V_ACT_LO, V_ACT_HI);

  always_ff @(posedge I_vtc_clk or posedge I_vtc_rst) begin
    if (I_vtc_rst) begin
      O_vtc_vs  <= ~VS_POL;
      O_vtc_hs  <= ~HS_POL;
      O_vtc_de  <= 1'b0;
      O_vtc_x   <= '0;
      O_vtc_y   <= '0;
      O_vtc_sof <= 1'b0;
    end else if (!counting) begin
      O_vtc_vs  <= ~VS_POL;
      O_vtc_hs  <= ~HS_POL;
      O_vtc_de  <= 1'b0;
      O_vtc_x   <= '0;
      O_vtc_y   <= '0;
      O_vtc_sof <= 1'b0;
    end else begin
      O_vtc_vs  <= (v_cnt < V_SYNC_E) ? VS_POL : ~VS_POL;
      O_vtc_hs  <= (h_cnt < H_SYNC_E) ? HS_POL : ~HS_POL;
      O_vtc_de  <= h_act && v_act;
      O_vtc_x   <= (h_act && v_act) ? h_cnt - H_ACT_LO : '0;
      O_vtc_y   <= (h_act && v_act) ? v_cnt - V_ACT_LO : '0;
      O_vtc_sof <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_uivtc_gen.sv
// tb/tb_uivtc_gen.sv - randomized self-checking bench for uivtc_gen against a frame-position model
module tb_uivtc_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        vs, hs, de, sof;
  logic [11:0] x, y;
  logic        vs_n, hs_n, de_n, sof_n;
  logic [11:0] x_n, y_n;

  always #5 clk = ~clk;

  uivtc_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut (
    .I_vtc_clk(clk), .I_vtc_rst(rst), .I_vtc_en(en),
    .O_vtc_vs(vs), .O_vtc_hs(hs), .O_vtc_de(de),
    .O_vtc_x(x), .O_vtc_y(y), .O_vtc_sof(sof)
  );

  uivtc_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_n (
    .I_vtc_clk(clk), .I_vtc_rst(rst), .I_vtc_en(en),
    .O_vtc_vs(vs_n), .O_vtc_hs(hs_n), .O_vtc_de(de_n),
    .O_vtc_x(x_n), .O_vtc_y(y_n), .O_vtc_sof(sof_n)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a frame is a run of FRAME positions; position p maps to h=p%HT, v=p/HT.
  // A frame ends the run only if en was low on its last edge and the edge before.
  bit   m_active  = 1'b0;
  bit   m_prev_en = 1'b0;
  int   m_pos     = 0;
  int   mh, mv;
  int   cyc       = 0;
  logic e_vs = 1'b0, e_hs = 1'b0, e_de = 1'b0, e_sof = 1'b0;
  int   e_x = 0, e_y = 0;

  always @(posedge clk) begin
    cyc++;
    e_vs = 1'b0; e_hs = 1'b0; e_de = 1'b0; e_sof = 1'b0; e_x = 0; e_y = 0;
    if (rst) begin
      m_active  = 1'b0;
      m_pos     = 0;
      m_prev_en = 1'b0;
    end else begin
      if (!m_active) begin
        if (en) begin
          m_active = 1'b1;
          m_pos    = 0;
        end
      end else begin
        mh    = m_pos % HT;
        mv    = m_pos / HT;
        e_hs  = (mh < HS);
        e_vs  = (mv < VS);
        e_de  = (mh >= HS + HB) && (mh < HS + HB + HA) && (mv >= VS + VB) && (mv < VS + VB + VA);
        if (e_de) begin
          e_x = mh - (HS + HB);
          e_y = mv - (VS + VB);
        end
        e_sof = (m_pos == 0);
        if (m_pos == FRAME - 1) begin
          m_pos = 0;
          if (!en && !m_prev_en) m_active = 1'b0;
        end else begin
          m_pos++;
        end
      end
      m_prev_en = en;
    end
  end

  bit gap_on   = 1'b0;
  int last_sof = -1;

  always @(negedge clk) begin
    check_eq("vs", vs, e_vs);
    check_eq("hs", hs, e_hs);
    check_eq("de", de, e_de);
    check_eq("x", x, e_x);
    check_eq("y", y, e_y);
    check_eq("sof", sof, e_sof);
    check_eq("vs_n", vs_n, !e_vs);
    check_eq("hs_n", hs_n, !e_hs);
    check_eq("de_n", de_n, e_de);
    check_eq("x_n", x_n, e_x);
    check_eq("y_n", y_n, e_y);
    check_eq("sof_n", sof_n, e_sof);
    if (!gap_on) begin
      last_sof = -1;
    end else if (sof) begin
      if (last_sof >= 0) check_eq("sof_gap", cyc - last_sof, FRAME);
      last_sof = cyc;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_vs"}, vs, 1'b0);
    check_eq({tag, "_hs"}, hs, 1'b0);
    check_eq({tag, "_de"}, de, 1'b0);
    check_eq({tag, "_x"}, x, 0);
    check_eq({tag, "_y"}, y, 0);
    check_eq({tag, "_sof"}, sof, 1'b0);
    check_eq({tag, "_vs_n"}, vs_n, 1'b1);
    check_eq({tag, "_hs_n"}, hs_n, 1'b1);
    check_eq({tag, "_de_n"}, de_n, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_idle("rst");
    @(negedge clk);
    #2 rst = 1'b0;
    cycles(50);
    check_idle("post_rst");

    // Continuous run: back-to-back frames.
    gap_on = 1'b1;
    en = 1'b1;
    cycles(FRAME * 3 + 5);
    en = 1'b0;
    cycles(FRAME + 10);
    gap_on = 1'b0;
    check_idle("stop1");

    // Drop en while the frame is on v=2.
    en = 1'b1;
    cycles(1 + 2 * HT + 3);
    en = 1'b0;
    cycles(FRAME * 2);
    check_idle("stop_mid");

    // Drop and re-raise while stopping: frames stay back-to-back.
    gap_on = 1'b1;
    en = 1'b1;
    cycles(150);
    en = 1'b0;
    cycles(20);
    en = 1'b1;
    cycles(FRAME * 3);
    en = 1'b0;
    cycles(FRAME + 5);
    gap_on = 1'b0;

    // Reset mid-frame: outputs go idle at once, no restart without en.
    en = 1'b1;
    cycles(60);
    #2 rst = 1'b1;
    en = 1'b0;
    #1 check_idle("async_rst");
    cycles(3);
    #2 rst = 1'b0;
    cycles(30);
    check_idle("after_rst");

    // Single-cycle en pulse produces exactly one frame.
    en = 1'b1;
    cycles(1);
    en = 1'b0;
    cycles(FRAME + 10);
    check_idle("pulse");

    // Random run/stop pattern.
    repeat (40) begin
      en = 1'($urandom_range(0, 1));
      cycles($urandom_range(1, 120));
    end
    en = 1'b0;
    cycles(FRAME * 2 + 5);
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
